// File: rtl/lsu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_responder
// Brief    : Memory-side responder for a load/store unit. Holds one pending
//            load and a 4-entry store FIFO, checks alignment, and serialises
//            accesses onto a simple req/ack word-wide memory port. A load waits
//            behind any queued store that targets the same word.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_responder (
  input  logic        Clk,
  input  logic        Rest,
  // load channel
  input  logic        LoadAble,
  input  logic [1:0]  LoadType,
  input  logic [31:0] LoadAddr,
  input  logic [4:0]  LoadBuffPtr,
  output logic        LoadBuzy,
  output logic        LoadSuccess,
  output logic [31:0] LoadDate,
  output logic [4:0]  LoadBackPtr,
  output logic        LoadTrapOut,
  // store channel
  input  logic        StoreAble,
  input  logic [1:0]  StoreType,
  input  logic [31:0] StoreAddr,
  input  logic [31:0] StoreDate,
  output logic        StoreBuzy,
  output logic        StoreTrapOut,
  output logic        DcacheFreeAll,
  // control
  input  logic        LsuFLash,
  // memory port
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [3:0]  MemWstrb,
  input  logic        MemAck,
  input  logic [31:0] MemRdata
);

  localparam logic [2:0] FIFO_DEPTH = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_MEM  = 2'd1,
    ST_MEM  = 2'd2,
    LD_RESP = 2'd3
  } state_t;

  // Type 3 is illegal; half needs addr[0]=0; word needs addr[1:0]=0.
  function automatic logic misaligned(input logic [1:0] t, input logic [1:0] a);
    case (t)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = (a != 2'd0);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [1:0] t, input logic [1:0] a);
    case (t)
      2'd0:    lane_strobe = 4'b0001 << a;
      2'd1:    lane_strobe = 4'b0011 << a;
      default: lane_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] t, input logic [31:0] d);
    case (t)
      2'd0:    lane_data = {4{d[7:0]}};
      2'd1:    lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  state_t       state_q, state_d;
  logic         ld_valid_q, ld_valid_d;
  logic [31:0]  ld_addr_q, ld_addr_d;
  logic [4:0]   ld_tag_q, ld_tag_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         flush_pend_q, flush_pend_d;
  logic         ld_trap_q, ld_trap_d;
  logic [4:0]   trap_tag_q, trap_tag_d;
  logic         st_trap_q, st_trap_d;
  logic [2:0]   count_q, count_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [29:0]  fifo_addr_q [4];
  logic [29:0]  fifo_addr_d [4];
  logic [31:0]  fifo_data_q [4];
  logic [31:0]  fifo_data_d [4];
  logic [3:0]   fifo_strb_q [4];
  logic [3:0]   fifo_strb_d [4];

  logic         w_idle, w_ld_acc, w_ld_bad, w_ld_new, w_ld_pend, w_ld_go;
  logic         w_st_acc, w_st_bad, w_st_push, w_pop;
  logic         w_fifo_match, w_same_cycle_hit;
  logic [29:0]  w_ld_word;
  logic [1:0]   w_off [4];

  assign w_idle    = (state_q == IDLE);
  assign LoadBuzy  = ld_valid_q | ~w_idle;
  assign StoreBuzy = (count_q == FIFO_DEPTH);

  assign w_ld_acc  = LoadAble & ~LoadBuzy;
  assign w_ld_bad  = misaligned(LoadType, LoadAddr[1:0]);
  // A flush in the acceptance cycle discards the incoming load as well.
  assign w_ld_new  = w_ld_acc & ~w_ld_bad & ~LsuFLash;
  assign w_st_acc  = StoreAble & ~StoreBuzy;
  assign w_st_bad  = misaligned(StoreType, StoreAddr[1:0]);
  assign w_st_push = w_st_acc & ~w_st_bad;
  assign w_pop     = (state_q == ST_MEM) & MemAck;

  // The candidate load is either the held one or the one arriving now,
  // which lets a fresh load reach the bus on the very next cycle.
  assign w_ld_pend = ~LsuFLash & (ld_valid_q | w_ld_new);
  assign w_ld_word = ld_valid_q ? ld_addr_q[31:2] : LoadAddr[31:2];
  // A store arriving alongside a new load is older, so it also blocks it.
  assign w_same_cycle_hit = w_ld_new & w_st_push & (StoreAddr[31:2] == LoadAddr[31:2]);
  assign w_ld_go   = w_idle & w_ld_pend & ~w_fifo_match & ~w_same_cycle_hit;

  // Search occupied FIFO slots for a store to the candidate load's word.
  always_comb begin
    w_fifo_match = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_off[i] = 2'(i) - rd_ptr_q;
      if (({1'b0, w_off[i]} < count_q) && (fifo_addr_q[i] == w_ld_word))
        w_fifo_match = 1'b1;
    end
  end

  // Next-state logic: loads take priority over store drain when unblocked.
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (w_ld_go)
          state_d = LD_MEM;
        else if (count_q != 3'd0)
          state_d = ST_MEM;
      end
      LD_MEM: begin
        if (MemAck) begin
          flush_pend_d = 1'b0;
          if (flush_pend_q | LsuFLash) begin
            state_d = IDLE;
          end else begin
            rdata_d = MemRdata;
            state_d = LD_RESP;
          end
        end else begin
          flush_pend_d = flush_pend_q | LsuFLash;
        end
      end
      ST_MEM: begin
        if (MemAck)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load register capture, issue and flush; alignment traps for both channels.
  always_comb begin
    ld_valid_d = ld_valid_q;
    ld_addr_d  = ld_addr_q;
    ld_tag_d   = ld_tag_q;
    if (w_ld_new) begin
      ld_valid_d = 1'b1;
      ld_addr_d  = LoadAddr;
      ld_tag_d   = LoadBuffPtr;
    end
    if (w_ld_go || LsuFLash)
      ld_valid_d = 1'b0;
    ld_trap_d  = w_ld_acc & w_ld_bad;
    trap_tag_d = (w_ld_acc & w_ld_bad) ? LoadBuffPtr : 5'd0;
    st_trap_d  = w_st_acc & w_st_bad;
  end

  // Store FIFO push/pop bookkeeping.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    fifo_strb_d = fifo_strb_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (w_st_push) begin
      fifo_addr_d[wr_ptr_q] = StoreAddr[31:2];
      fifo_data_d[wr_ptr_q] = lane_data(StoreType, StoreDate);
      fifo_strb_d[wr_ptr_q] = lane_strobe(StoreType, StoreAddr[1:0]);
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (w_pop)
      rd_ptr_d = rd_ptr_q + 2'd1;
    case ({w_st_push, w_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q      <= IDLE;
      ld_valid_q   <= 1'b0;
      ld_addr_q    <= 32'd0;
      ld_tag_q     <= 5'd0;
      rdata_q      <= 32'd0;
      flush_pend_q <= 1'b0;
      ld_trap_q    <= 1'b0;
      trap_tag_q   <= 5'd0;
      st_trap_q    <= 1'b0;
      count_q      <= 3'd0;
      rd_ptr_q     <= 2'd0;
      wr_ptr_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      ld_valid_q   <= ld_valid_d;
      ld_addr_q    <= ld_addr_d;
      ld_tag_q     <= ld_tag_d;
      rdata_q      <= rdata_d;
      flush_pend_q <= flush_pend_d;
      ld_trap_q    <= ld_trap_d;
      trap_tag_q   <= trap_tag_d;
      st_trap_q    <= st_trap_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // FIFO payload storage; occupancy is tracked by the pointers above.
  always_ff @(posedge Clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
    fifo_strb_q <= fifo_strb_d;
  end

  // Outputs decoded from registered state only; idle lanes drive zero.
  always_comb begin
    MemReq      = (state_q == LD_MEM) | (state_q == ST_MEM);
    MemWe       = (state_q == ST_MEM);
    MemAddr     = 32'd0;
    MemWdata    = 32'd0;
    MemWstrb    = 4'd0;
    if (state_q == LD_MEM) begin
      MemAddr = {ld_addr_q[31:2], 2'b00};
    end else if (state_q == ST_MEM) begin
      MemAddr  = {fifo_addr_q[rd_ptr_q], 2'b00};
      MemWdata = fifo_data_q[rd_ptr_q];
      MemWstrb = fifo_strb_q[rd_ptr_q];
    end
    LoadTrapOut   = ld_trap_q;
    LoadSuccess   = (state_q == LD_RESP) & ~ld_trap_q;
    LoadDate      = LoadSuccess ? rdata_q : 32'd0;
    LoadBackPtr   = ld_trap_q ? trap_tag_q : (LoadSuccess ? ld_tag_q : 5'd0);
    StoreTrapOut  = st_trap_q;
    DcacheFreeAll = (count_q == 3'd0) & ~ld_valid_q & w_idle;
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_responder
// Brief    : Directed testbench for lsu_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_responder;

  logic        Clk = 1'b0;
  logic        Rest;
  logic        LoadAble;
  logic [1:0]  LoadType;
  logic [31:0] LoadAddr;
  logic [4:0]  LoadBuffPtr;
  logic        LoadBuzy, LoadSuccess, LoadTrapOut;
  logic [31:0] LoadDate;
  logic [4:0]  LoadBackPtr;
  logic        StoreAble;
  logic [1:0]  StoreType;
  logic [31:0] StoreAddr, StoreDate;
  logic        StoreBuzy, StoreTrapOut, DcacheFreeAll;
  logic        LsuFLash;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWdata;
  logic [3:0]  MemWstrb;
  logic        MemAck;
  logic [31:0] MemRdata;

  int checks = 0;
  int failures = 0;
  int n_drain;

  lsu_mem_responder dut (
    .Clk(Clk), .Rest(Rest),
    .LoadAble(LoadAble), .LoadType(LoadType), .LoadAddr(LoadAddr),
    .LoadBuffPtr(LoadBuffPtr), .LoadBuzy(LoadBuzy), .LoadSuccess(LoadSuccess),
    .LoadDate(LoadDate), .LoadBackPtr(LoadBackPtr), .LoadTrapOut(LoadTrapOut),
    .StoreAble(StoreAble), .StoreType(StoreType), .StoreAddr(StoreAddr),
    .StoreDate(StoreDate), .StoreBuzy(StoreBuzy), .StoreTrapOut(StoreTrapOut),
    .DcacheFreeAll(DcacheFreeAll), .LsuFLash(LsuFLash),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemWstrb(MemWstrb), .MemAck(MemAck), .MemRdata(MemRdata)
  );

  always #5 Clk = ~Clk;

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    Rest = 1'b1; LoadAble = 1'b0; LoadType = 2'd0; LoadAddr = 32'd0; LoadBuffPtr = 5'd0;
    StoreAble = 1'b0; StoreType = 2'd0; StoreAddr = 32'd0; StoreDate = 32'd0;
    LsuFLash = 1'b0; MemAck = 1'b0; MemRdata = 32'd0;
    tick(); tick();
    chk("rst_free",     32'(DcacheFreeAll), 32'd1);
    chk("rst_memreq",   32'(MemReq),        32'd0);
    chk("rst_ldbuzy",   32'(LoadBuzy),      32'd0);
    chk("rst_stbuzy",   32'(StoreBuzy),     32'd0);
    chk("rst_ldsucc",   32'(LoadSuccess),   32'd0);
    Rest = 1'b0;
    tick();

    // Word load 0x1000 tag 5, zero-wait memory.
    LoadAble = 1'b1; LoadType = 2'd2; LoadAddr = 32'h1000; LoadBuffPtr = 5'd5;
    MemAck = 1'b1; MemRdata = 32'hDEADBEEF;
    tick();
    LoadAble = 1'b0;
    chk("ld_t1_memreq", 32'(MemReq),  32'd1);
    chk("ld_t1_memwe",  32'(MemWe),   32'd0);
    chk("ld_t1_addr",   MemAddr,      32'h1000);
    chk("ld_t1_succ",   32'(LoadSuccess), 32'd0);
    tick();
    MemAck = 1'b0;
    chk("ld_t2_succ",   32'(LoadSuccess), 32'd1);
    chk("ld_t2_data",   LoadDate,     32'hDEADBEEF);
    chk("ld_t2_ptr",    32'(LoadBackPtr), 32'd5);
    tick();
    chk("ld_t3_succ",   32'(LoadSuccess), 32'd0);
    chk("ld_t3_free",   32'(DcacheFreeAll), 32'd1);

    // Byte store 0x2003 data 0xAB.
    StoreAble = 1'b1; StoreType = 2'd0; StoreAddr = 32'h2003; StoreDate = 32'h000000AB;
    tick();
    StoreAble = 1'b0;
    chk("stb_t1_free",  32'(DcacheFreeAll), 32'd0);
    chk("stb_t1_req",   32'(MemReq),  32'd0);
    tick();
    chk("stb_req",      32'(MemReq),  32'd1);
    chk("stb_we",       32'(MemWe),   32'd1);
    chk("stb_addr",     MemAddr,      32'h2000);
    chk("stb_strb",     32'(MemWstrb), 32'h8);
    chk("stb_wdata",    MemWdata,     32'hABABABAB);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    chk("stb_done_req", 32'(MemReq),  32'd0);
    chk("stb_done_free", 32'(DcacheFreeAll), 32'd1);

    // Half store 0x2002 data 0x1234.
    StoreAble = 1'b1; StoreType = 2'd1; StoreAddr = 32'h2002; StoreDate = 32'hFFFF1234;
    tick();
    StoreAble = 1'b0;
    tick();
    chk("sth_strb",     32'(MemWstrb), 32'hC);
    chk("sth_wdata",    MemWdata,     32'h12341234);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;

    // Misaligned half load 0x4001 tag 9.
    LoadAble = 1'b1; LoadType = 2'd1; LoadAddr = 32'h4001; LoadBuffPtr = 5'd9;
    tick();
    LoadAble = 1'b0;
    chk("ldtrap_out",   32'(LoadTrapOut), 32'd1);
    chk("ldtrap_ptr",   32'(LoadBackPtr), 32'd9);
    chk("ldtrap_req",   32'(MemReq),  32'd0);
    chk("ldtrap_succ",  32'(LoadSuccess), 32'd0);
    tick();
    chk("ldtrap_clr",   32'(LoadTrapOut), 32'd0);
    chk("ldtrap_req2",  32'(MemReq),  32'd0);

    // Misaligned word store 0x5002.
    StoreAble = 1'b1; StoreType = 2'd2; StoreAddr = 32'h5002; StoreDate = 32'h1;
    tick();
    StoreAble = 1'b0;
    chk("sttrap_out",   32'(StoreTrapOut), 32'd1);
    chk("sttrap_free",  32'(DcacheFreeAll), 32'd1);
    tick();
    chk("sttrap_clr",   32'(StoreTrapOut), 32'd0);
    chk("sttrap_req",   32'(MemReq),  32'd0);

    // Same-cycle store 0x3000 and half load 0x3002: store goes first.
    StoreAble = 1'b1; StoreType = 2'd2; StoreAddr = 32'h3000; StoreDate = 32'h11223344;
    LoadAble = 1'b1; LoadType = 2'd1; LoadAddr = 32'h3002; LoadBuffPtr = 5'd3;
    tick();
    StoreAble = 1'b0; LoadAble = 1'b0;
    chk("haz_t1_ldbuzy", 32'(LoadBuzy), 32'd1);
    chk("haz_t1_req",   32'(MemReq),  32'd0);
    tick();
    chk("haz_st_req",   32'(MemReq),  32'd1);
    chk("haz_st_we",    32'(MemWe),   32'd1);
    chk("haz_st_addr",  MemAddr,      32'h3000);
    MemAck = 1'b1; MemRdata = 32'hCAFEF00D;
    tick();
    MemAck = 1'b0;
    chk("haz_gap_req",  32'(MemReq),  32'd0);
    tick();
    chk("haz_ld_req",   32'(MemReq),  32'd1);
    chk("haz_ld_we",    32'(MemWe),   32'd0);
    chk("haz_ld_addr",  MemAddr,      32'h3000);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    chk("haz_ld_succ",  32'(LoadSuccess), 32'd1);
    chk("haz_ld_data",  LoadDate,     32'hCAFEF00D);
    chk("haz_ld_ptr",   32'(LoadBackPtr), 32'd3);
    tick();
    chk("haz_free",     32'(DcacheFreeAll), 32'd1);

    // Five stores with MemAck low: fourth fills the FIFO, fifth refused.
    for (int i = 0; i < 5; i++) begin
      chk("fill_stbuzy", 32'(StoreBuzy), (i == 4) ? 32'd1 : 32'd0);
      StoreAble = 1'b1; StoreType = 2'd2;
      StoreAddr = 32'h6000 + 32'(4 * i); StoreDate = 32'(i);
      tick();
    end
    StoreAble = 1'b0;
    chk("full_stbuzy",  32'(StoreBuzy), 32'd1);
    chk("full_free",    32'(DcacheFreeAll), 32'd0);
    MemAck = 1'b1;
    n_drain = 0;
    for (int k = 0; k < 20; k++) begin
      if (MemReq && MemWe) begin
        chk("drain_addr", MemAddr, 32'h6000 + 32'(4 * n_drain));
        n_drain++;
      end
      tick();
    end
    MemAck = 1'b0;
    chk("drain_count",  32'(n_drain), 32'd4);
    chk("drain_free",   32'(DcacheFreeAll), 32'd1);

    // Flush during LD_MEM; ack three cycles later; no success.
    LoadAble = 1'b1; LoadType = 2'd2; LoadAddr = 32'h7000; LoadBuffPtr = 5'd2;
    tick();
    LoadAble = 1'b0;
    chk("fl_req",       32'(MemReq),  32'd1);
    LsuFLash = 1'b1;
    tick();
    LsuFLash = 1'b0;
    chk("fl_req_hold",  32'(MemReq),  32'd1);
    chk("fl_addr_hold", MemAddr,      32'h7000);
    tick();
    tick();
    MemAck = 1'b1;
    chk("fl_req_ack",   32'(MemReq),  32'd1);
    tick();
    MemAck = 1'b0;
    chk("fl_succ",      32'(LoadSuccess), 32'd0);
    chk("fl_req_off",   32'(MemReq),  32'd0);
    chk("fl_free",      32'(DcacheFreeAll), 32'd1);
    tick();
    chk("fl_succ2",     32'(LoadSuccess), 32'd0);

    // Reset in the middle of a load.
    LoadAble = 1'b1; LoadType = 2'd2; LoadAddr = 32'h8000; LoadBuffPtr = 5'd4;
    tick();
    LoadAble = 1'b0;
    chk("mrst_req",     32'(MemReq),  32'd1);
    Rest = 1'b1;
    tick();
    Rest = 1'b0; MemAck = 1'b1;
    chk("mrst_req_off", 32'(MemReq),  32'd0);
    chk("mrst_ldbuzy",  32'(LoadBuzy), 32'd0);
    chk("mrst_free",    32'(DcacheFreeAll), 32'd1);
    tick();
    MemAck = 1'b0;
    chk("mrst_succ",    32'(LoadSuccess), 32'd0);
    chk("mrst_req2",    32'(MemReq),  32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_responder.md
LSU_MEM_RESPONDER -- requirements
Module: lsu_mem_responder

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock; Rest  in  1  reset, synchronous, active-high.
REQ-002 SHALL have LSU load ports: LoadAble in 1 request; LoadType in 2 (0 byte, 1 half, 2 word, 3 illegal); LoadAddr in 32; LoadBuffPtr in 5 tag; LoadBuzy out 1; LoadSuccess out 1; LoadDate out 32 aligned word; LoadBackPtr out 5; LoadTrapOut out 1.
REQ-003 SHALL have LSU store ports: StoreAble in 1; StoreType in 2; StoreAddr in 32; StoreDate in 32; StoreBuzy out 1; StoreTrapOut out 1; DcacheFreeAll out 1 idle/drained.
REQ-004 SHALL have control port LsuFLash in 1 (flush).
REQ-005 SHALL have memory ports: MemReq out 1; MemWe out 1; MemAddr out 32 word-aligned; MemWdata out 32; MemWstrb out 4; MemAck in 1; MemRdata in 32.

Function
REQ-006 Load accepted when LoadAble=1 and LoadBuzy=0; captured into a one-entry load register.
REQ-007 Store accepted when StoreAble=1 and StoreBuzy=0; enqueued into a 4-entry FIFO of {word addr, lane-replicated data, strobe}.
REQ-008 Misaligned or illegal access (half addr[0]=1; word addr[1:0]!=0; type 3) SHALL NOT reach memory; load: LoadTrapOut=1 with LoadBackPtr=tag for one cycle at T+1, LoadSuccess=0; store: StoreTrapOut=1 for one cycle at T+1, not enqueued.
REQ-009 Strobe: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-010 FSM states IDLE, LD_MEM, ST_MEM, LD_RESP.
REQ-011 IDLE: valid load with no word-address match in store FIFO -> LD_MEM; else FIFO non-empty -> ST_MEM (drains head); else stay.
REQ-012 Load whose word address matches any FIFO entry SHALL wait until matching stores drain; a store accepted in the same cycle as a load is older than it.
REQ-013 LD_MEM/ST_MEM: MemReq=1, MemWe=0/1, MemAddr/MemWdata/MemWstrb held stable until MemAck=1.
REQ-014 MemAck in LD_MEM: capture MemRdata -> LD_RESP; next cycle LoadSuccess=1 one cycle, LoadDate=captured word, LoadBackPtr=tag; -> IDLE.
REQ-015 MemAck in ST_MEM: pop FIFO head -> IDLE.
REQ-016 Latency: zero-wait memory, load accepted at T gives MemReq at T+1, LoadSuccess at T+2.
REQ-017 LoadBuzy=1 while load register valid or FSM != IDLE; StoreBuzy=1 when FIFO count=4, including a same-cycle pop.
REQ-018 Load-trap and load-success pulses SHALL never coincide; trap pulse takes LoadBackPtr priority.
REQ-019 LsuFLash: clears unissued load register; if in LD_MEM, completes bus handshake, then suppresses LoadSuccess; store FIFO and ST_MEM unaffected.
REQ-020 DcacheFreeAll=1 when FIFO empty, load register empty, FSM=IDLE.
REQ-021 MemAck outside LD_MEM/ST_MEM SHALL be ignored.

Reset
REQ-022 Rest=1: FSM IDLE, FIFO empty, load register empty.
REQ-023 Rest=1: all outputs 0 from next edge, except DcacheFreeAll=1.
REQ-024 Reset mid-transaction: MemReq deasserts next cycle; in-flight load/store discarded, no LoadSuccess.

Verification
REQ-025 Word load 0x1000 tag 5, MemAck same cycle, MemRdata=0xDEADBEEF -> MemReq T+1, LoadSuccess T+2, LoadDate=0xDEADBEEF, LoadBackPtr=5.
REQ-026 Byte store 0x2003 data 0xAB -> MemWe=1, MemAddr=0x2000, MemWstrb=4'b1000, MemWdata=0xABABABAB.
REQ-027 Five stores with MemAck held low -> StoreBuzy=1 after fourth; fifth refused; DcacheFreeAll=0.
REQ-028 Store 0x3000 and load 0x3002 same cycle -> store issued first, load MemReq only after store MemAck.
REQ-029 Half load 0x4001 tag 9 -> LoadTrapOut=1, LoadBackPtr=9 at T+1, no MemReq.
REQ-030 Load in LD_MEM, LsuFLash pulse, MemAck 3 cycles later -> no LoadSuccess, DcacheFreeAll=1 next cycle.
